// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 16:1 mux; a grant appears one edge after the request is seen in IDLE.
// The grant is held until ack or watchdog expiry, and each exit is followed by one IDLE bubble cycle.
module mux16_rr_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_req,
    input  logic        i_ack,
    output logic [3:0]  o_sel,
    output logic [15:0] o_gnt,
    output logic        o_valid,
    output logic        o_timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ptr;
    logic [3:0]  w_ptr_nxt;
    logic [7:0]  r_wd;
    logic [7:0]  w_wd_nxt;
    logic [3:0]  r_sel;
    logic [3:0]  w_sel_nxt;
    logic [15:0] r_gnt;
    logic [15:0] w_gnt_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;

    logic [15:0] w_rot;
    logic [3:0]  w_win_off;
    logic [3:0]  w_win_idx;
    logic        w_any_req;

    // Rotate requests so bit 0 is the current priority position, then take the lowest set bit.
    always_comb begin
        w_rot     = 16'({i_req, i_req} >> r_ptr);
        w_any_req = |i_req;
        w_win_off = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_win_off = 4'(k);
            end
        end
        w_win_idx = r_ptr + w_win_off;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wd_nxt      = r_wd;
        w_sel_nxt     = r_sel;
        w_gnt_nxt     = r_gnt;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win_idx;
                    w_gnt_nxt   = 16'h0001 << w_win_idx;
                    w_valid_nxt = 1'b1;
                    w_wd_nxt    = 8'd0;
                end
            end
            S_GRANT: begin
                // ack takes precedence over a watchdog expiry on the same edge
                if (i_ack || (r_wd == WD_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_ptr_nxt     = r_sel + 4'd1;
                    w_gnt_nxt     = 16'h0000;
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = ~i_ack;
                end else begin
                    w_wd_nxt = r_wd + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 4'd0;
            r_wd      <= 8'd0;
            r_sel     <= 4'd0;
            r_gnt     <= 16'h0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wd      <= w_wd_nxt;
            r_sel     <= w_sel_nxt;
            r_gnt     <= w_gnt_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_sel     = r_sel;
    assign o_gnt     = r_gnt;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized and directed bench for mux16_rr_arbiter against a cycle-level behavioural model.
module tb_mux16_rr_arbiter;

    localparam int TO = 8;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_req;
    logic        i_ack;
    logic [3:0]  o_sel;
    logic [15:0] o_gnt;
    logic        o_valid;
    logic        o_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: who holds the mux, for how long, and where the scan starts.
    bit m_busy;
    int m_ptr;
    int m_sel;
    int m_held;
    bit m_to;

    mux16_rr_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_ack     (i_ack),
        .o_sel     (o_sel),
        .o_gnt     (o_gnt),
        .o_valid   (o_valid),
        .o_timeout (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [15:0] exp_gnt();
        return m_busy ? (16'h0001 << m_sel) : 16'h0000;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_ptr  = 0;
        m_sel  = 0;
        m_held = 0;
        m_to   = 0;
    endtask

    task automatic model_edge(input logic [15:0] req, input logic ack);
        m_to = 0;
        if (m_busy) begin
            m_held = m_held + 1;
            if (ack || m_held == TO) begin
                m_busy = 0;
                m_to   = !ack;
                m_ptr  = (m_sel + 1) % 16;
            end
        end else if (req != 0) begin
            for (int k = 0; k < 16; k++) begin
                if (!m_busy && req[(m_ptr + k) % 16]) begin
                    m_busy = 1;
                    m_sel  = (m_ptr + k) % 16;
                    m_held = 0;
                end
            end
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model, settle 1 time unit.
    task automatic drive_cycle(input logic [15:0] req, input logic ack);
        i_req = req;
        i_ack = ack;
        @(posedge i_clk);
        model_edge(req, ack);
        #1;
    endtask

    task automatic hard_reset();
        i_rst = 1'b1;
        i_req = 16'h0000;
        i_ack = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        hard_reset();
        n_checks++;
        if (o_valid !== 1'b0 || o_gnt !== 16'h0 || o_sel !== 4'd0 || o_timeout !== 1'b0)
            $display("FAIL reset_idle: valid=%b gnt=%h sel=%0d timeout=%b, want 0/0000/0/0", o_valid, o_gnt, o_sel, o_timeout);
        else n_pass++;

        drive_cycle(16'h0020, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd5 || o_gnt !== 16'h0020)
            $display("FAIL reset_pre_grant: valid=%b sel=%0d gnt=%h, want 1/5/0020", o_valid, o_sel, o_gnt);
        else n_pass++;

        #2;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_gnt !== 16'h0 || o_sel !== 4'd0 || o_timeout !== 1'b0)
            $display("FAIL reset_async: valid=%b gnt=%h sel=%0d timeout=%b, want 0/0000/0/0", o_valid, o_gnt, o_sel, o_timeout);
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();

        drive_cycle(16'h0001, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd0 || o_gnt !== 16'h0001)
            $display("FAIL reset_regrant: valid=%b sel=%0d gnt=%h, want 1/0/0001", o_valid, o_sel, o_gnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int          order [9] = '{1, 3, 8, 9, 10, 11, 12, 13, 1};
        logic [15:0] mux_in = 16'h3f0a;
        hard_reset();
        for (int g = 0; g < 9; g++) begin
            drive_cycle(16'h3f0a, 1'b0);
            n_checks++;
            if (o_valid !== 1'b1 || o_sel !== 4'(order[g]) || o_gnt !== (16'h0001 << order[g]) || mux_in[o_sel] !== 1'b1)
                $display("FAIL rr_grant%0d: valid=%b sel=%0d gnt=%h, want 1/%0d", g, o_valid, o_sel, o_gnt, order[g]);
            else n_pass++;
            drive_cycle(16'h3f0a, 1'b1);
            n_checks++;
            if (o_valid !== 1'b0 || o_gnt !== 16'h0 || o_sel !== 4'(order[g]))
                $display("FAIL rr_bubble%0d: valid=%b gnt=%h sel=%0d, want 0/0000/%0d", g, o_valid, o_gnt, o_sel, order[g]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        hard_reset();
        drive_cycle(16'h4000, 1'b0);
        drive_cycle(16'h0000, 1'b1);
        drive_cycle(16'h8001, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd15 || o_gnt !== 16'h8000)
            $display("FAIL wrap_15: valid=%b sel=%0d gnt=%h, want 1/15/8000", o_valid, o_sel, o_gnt);
        else n_pass++;
        drive_cycle(16'h8001, 1'b1);
        drive_cycle(16'h8001, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd0 || o_gnt !== 16'h0001)
            $display("FAIL wrap_0: valid=%b sel=%0d gnt=%h, want 1/0/0001", o_valid, o_sel, o_gnt);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int held = 0;
        hard_reset();
        drive_cycle(16'h0040, 1'b0);
        for (int c = 0; c < 20 && o_valid === 1'b1; c++) begin
            if (o_sel === 4'd6 && o_timeout === 1'b0) held++;
            drive_cycle(16'h0040, 1'b0);
        end
        n_checks++;
        if (held !== TO)
            $display("FAIL wd_hold: granted cycles=%0d, want %0d", held, TO);
        else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0 || o_timeout !== 1'b1 || o_gnt !== 16'h0)
            $display("FAIL wd_drop: valid=%b timeout=%b gnt=%h, want 0/1/0000", o_valid, o_timeout, o_gnt);
        else n_pass++;
        drive_cycle(16'h0040, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd6 || o_timeout !== 1'b0)
            $display("FAIL wd_regrant: valid=%b sel=%0d timeout=%b, want 1/6/0", o_valid, o_sel, o_timeout);
        else n_pass++;
    endtask

    task automatic test_collision();
        hard_reset();
        drive_cycle(16'h0040, 1'b0);
        for (int c = 1; c < TO; c++) drive_cycle(16'h0040, 1'b0);
        drive_cycle(16'h0040, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || o_timeout !== 1'b0)
            $display("FAIL coll_exit: valid=%b timeout=%b, want 0/0", o_valid, o_timeout);
        else n_pass++;
        drive_cycle(16'h00c0, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd7)
            $display("FAIL coll_ptr: valid=%b sel=%0d, want 1/7", o_valid, o_sel);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        hard_reset();
        drive_cycle(16'h1000, 1'b0);
        for (int c = 0; c < 4; c++) drive_cycle(16'h0000, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_gnt !== 16'h1000)
            $display("FAIL wd_withdraw_hold: valid=%b gnt=%h, want 1/1000", o_valid, o_gnt);
        else n_pass++;
        drive_cycle(16'h0000, 1'b1);
        for (int c = 0; c < 3; c++) drive_cycle(16'h0000, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || o_gnt !== 16'h0 || o_sel !== 4'd12 || o_timeout !== 1'b0)
            $display("FAIL idle_ack: valid=%b gnt=%h sel=%0d timeout=%b, want 0/0000/12/0", o_valid, o_gnt, o_sel, o_timeout);
        else n_pass++;
        drive_cycle(16'h1001, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || o_sel !== 4'd0)
            $display("FAIL withdraw_ptr: valid=%b sel=%0d, want 1/0", o_valid, o_sel);
        else n_pass++;
    endtask

    task automatic test_random();
        int          bad = 0;
        logic [15:0] r;
        logic        a;
        hard_reset();
        for (int c = 0; c < 600; c++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 4) == 0) r = 16'h0000;
            a = ($urandom_range(0, 5) == 0);
            drive_cycle(r, a);
            if (o_valid !== m_busy || o_sel !== 4'(m_sel) || o_gnt !== exp_gnt() || o_timeout !== m_to) begin
                if (bad < 5)
                    $display("FAIL rand_cycle%0d: valid=%b sel=%0d gnt=%h to=%b, want %b/%0d/%h/%b",
                             c, o_valid, o_sel, o_gnt, o_timeout, m_busy, m_sel, exp_gnt(), m_to);
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL rand_total: mismatched cycles=%0d, want 0", bad);
        else n_pass++;
    endtask

    initial begin
        i_rst = 1'b1;
        i_req = 16'h0000;
        i_ack = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_wrap();
        test_watchdog();
        test_collision();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
